// File: rtl/tt_div_pkg.sv
// Shared encodings and widths for the 8-bit by 4-bit restoring divider.
package tt_div_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int ITER  = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] UIO_OE_CONST = 8'b1100_0000;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module div_step
    import tt_div_pkg::*;
(
    input  logic [DVS_W:0]   prem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] dvs_i,
    output logic [DVS_W:0]   prem_o,
    output logic             q_o
);

    logic [DVS_W:0]   trial;
    logic [DVS_W+1:0] diff;
    logic             fits;
    logic             unused_prem_msb;

    // The incoming remainder is always below the divisor, so its MSB is zero.
    assign unused_prem_msb = prem_i[DVS_W];

    always_comb begin
        trial  = {prem_i[DVS_W-1:0], bit_i};
        diff   = {1'b0, trial} - {2'b00, dvs_i};
        fits   = ~diff[DVS_W+1];
        q_o    = fits;
        prem_o = fits ? diff[DVS_W:0] : trial;
    end

endmodule

// File: rtl/tt_um_div.sv
// Tiny Tapeout 8/4-bit sequential restoring divider with start-edge control.
// Define TT_DIV_REM_EN to let uio_in[5] (show_rem) display the remainder.
module tt_um_div
    import tt_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t state_q, state_d;

    logic             start_prev_q, start_prev_d;
    logic             armed_q, armed_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W:0]   prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;

    logic             start;
    logic             start_evt;
    logic [DVS_W:0]   step_prem;
    logic             step_q;
    logic             busy;
    logic             done;

    assign start = uio_in[4];
    // armed_q only rises once start has been seen low, so a start held high
    // through reset never counts as an edge.
    assign start_evt = start & ~start_prev_q & armed_q;

    div_step u_step (
        .prem_i (prem_q),
        .bit_i  (dvd_q[DVD_W-1]),
        .dvs_i  (dvs_q),
        .prem_o (step_prem),
        .q_o    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_evt) state_d = RUN;
            RUN:     if (cnt_q == ITER_LAST) state_d = DONE;
            DONE:    if (start_evt) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            prem_q       <= '0;
            cnt_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
        end else if (ena) begin
            start_prev_q <= start_prev_d;
            armed_q      <= armed_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            prem_q       <= prem_d;
            cnt_q        <= cnt_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
        end
    end

    always_comb begin
        start_prev_d = start;
        armed_d      = armed_q | ~start;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        prem_d       = prem_q;
        cnt_d        = cnt_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_evt) begin
                    dvd_d  = ui_in;
                    dvs_d  = uio_in[DVS_W-1:0];
                    prem_d = '0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                if (cnt_q != ITER_LAST) begin
                    // Quotient bits shift into the vacated dividend LSBs.
                    prem_d = step_prem;
                    dvd_d  = {dvd_q[DVD_W-2:0], step_q};
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    quo_d = dvd_q;
                    rem_d = prem_q[DVS_W-1:0];
                end
            end
            default: ;
        endcase
    end

`ifdef TT_DIV_REM_EN
    logic unused_in;
    assign unused_in = ^uio_in[7:6];
    assign uo_out = uio_in[5] ? {4'b0000, rem_q} : quo_q;
`else
    logic unused_in;
    assign unused_in = ^{uio_in[7:5], rem_q};
    assign uo_out = quo_q;
`endif

    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = UIO_OE_CONST;

endmodule

// File: tb/tb_tt_um_div.sv
// Directed bench for tt_um_div: latency, results, restart-ignore, reset abort, ena stall.
module tb_tt_um_div;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int nvec;
    int nerr;

    tt_um_div dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start with operands for one edge (the capture edge), then drop it.
    task automatic pulse_start(input logic [7:0] a, input logic [3:0] b, input logic show);
        ui_in  = a;
        uio_in = {2'b00, show, 1'b1, b};
        tick();
        uio_in[4] = 1'b0;
        $display("start %0d / %0d", a, b);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (uio_out[7] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;
        nvec++;
        if (uo_out !== 8'h00) begin nerr++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
        nvec++;
        if (uio_out !== 8'h00) begin nerr++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
        nvec++;
        if (uio_oe !== 8'hC0) begin nerr++; $display("FAIL uio_oe got %h want c0", uio_oe); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        nvec++;
        if (uio_out !== 8'h00) begin nerr++; $display("FAIL idle_flags got %h want 00", uio_out); end
        $display("reset: uo_out=%h uio_out=%h", uo_out, uio_out);
    endtask

    task automatic test_basic();
        int n;
        pulse_start(8'd221, 4'd13, 1'b0);
        nvec++;
        if (uio_out[7:6] !== 2'b01) begin nerr++; $display("FAIL basic_busy got %b want 01", uio_out[7:6]); end
        n = 0;
        // Busy must stay up without done for the 8 edges after capture.
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            nvec++;
            if (uio_out[7:6] !== 2'b01) begin nerr++; $display("FAIL basic_run_flags cyc %0d got %b want 01", n, uio_out[7:6]); end
        end
        tick();
        n++;
        nvec++;
        if (uio_out[7:6] !== 2'b10) begin nerr++; $display("FAIL basic_done_at9 got %b want 10", uio_out[7:6]); end
        nvec++;
        if (uo_out !== 8'd17) begin nerr++; $display("FAIL basic_quot got %0d want 17", uo_out); end
`ifdef TT_DIV_REM_EN
        uio_in[5] = 1'b1;
        #1;
        nvec++;
        if (uo_out !== 8'h00) begin nerr++; $display("FAIL basic_rem got %h want 00", uo_out); end
        uio_in[5] = 1'b0;
        #1;
`endif
        $display("221/13 -> uo_out=%0d after %0d cycles", uo_out, n);
    endtask

    task automatic test_rem();
        int n;
        pulse_start(8'd200, 4'd7, 1'b0);
        wait_done(n);
        nvec++;
        if (n !== 9) begin nerr++; $display("FAIL rem_latency got %0d want 9", n); end
        nvec++;
        if (uo_out !== 8'h1C) begin nerr++; $display("FAIL rem_quot got %h want 1c", uo_out); end
        uio_in[5] = 1'b1;
        #1;
`ifdef TT_DIV_REM_EN
        nvec++;
        if (uo_out !== 8'h04) begin nerr++; $display("FAIL rem_show got %h want 04", uo_out); end
`else
        nvec++;
        if (uo_out !== 8'h1C) begin nerr++; $display("FAIL show_rem_ignored got %h want 1c", uo_out); end
`endif
        uio_in[5] = 1'b0;
        #1;
        $display("200/7 -> uo_out=%h after %0d cycles", uo_out, n);
    endtask

    task automatic test_div0();
        int n;
        pulse_start(8'd5, 4'd0, 1'b0);
        wait_done(n);
        nvec++;
        if (n !== 9) begin nerr++; $display("FAIL div0_latency got %0d want 9", n); end
        nvec++;
        if (uo_out !== 8'hFF) begin nerr++; $display("FAIL div0_quot got %h want ff", uo_out); end
`ifdef TT_DIV_REM_EN
        uio_in[5] = 1'b1;
        #1;
        nvec++;
        if (uo_out !== 8'h05) begin nerr++; $display("FAIL div0_rem got %h want 05", uo_out); end
        uio_in[5] = 1'b0;
        #1;
`endif
        $display("5/0 -> uo_out=%h after %0d cycles", uo_out, n);
    endtask

    task automatic test_ignore_restart();
        int n;
        pulse_start(8'd221, 4'd13, 1'b0);
        tick();
        tick();
        pulse_start(8'd100, 4'd3, 1'b0);
        wait_done(n);
        nvec++;
        if (n + 3 !== 9) begin nerr++; $display("FAIL restart_latency got %0d want 9", n + 3); end
        nvec++;
        if (uo_out !== 8'd17) begin nerr++; $display("FAIL restart_quot got %0d want 17", uo_out); end
        ui_in = 8'd99;
        tick();
        tick();
        tick();
        nvec++;
        if (uo_out !== 8'd17 || uio_out[7:6] !== 2'b10) begin
            nerr++;
            $display("FAIL done_hold got uo=%0d flags=%b want 17 10", uo_out, uio_out[7:6]);
        end
        $display("ignored restart -> uo_out=%0d", uo_out);
    endtask

    task automatic test_reset_mid_run();
        int n;
        ui_in  = 8'd221;
        uio_in = {4'b0001, 4'd13};
        tick();
        tick();
        tick();
        tick();
        nvec++;
        if (uo_out !== 8'd17) begin nerr++; $display("FAIL pre_abort_hold got %0d want 17", uo_out); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            nerr++;
            $display("FAIL abort_outputs got uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        nvec++;
        if (uio_out[7:6] !== 2'b00) begin nerr++; $display("FAIL held_start_ignored got %b want 00", uio_out[7:6]); end
        uio_in[4] = 1'b0;
        tick();
        uio_in[4] = 1'b1;
        tick();
        nvec++;
        if (uio_out[7:6] !== 2'b01) begin nerr++; $display("FAIL fresh_start got %b want 01", uio_out[7:6]); end
        uio_in[4] = 1'b0;
        wait_done(n);
        nvec++;
        if (n !== 9 || uo_out !== 8'd17) begin
            nerr++;
            $display("FAIL post_reset_op got n=%0d q=%0d want 9 17", n, uo_out);
        end
        $display("reset abort -> rerun uo_out=%0d after %0d cycles", uo_out, n);
    endtask

    task automatic test_ena_stall();
        int n;
        pulse_start(8'd200, 4'd7, 1'b0);
        tick();
        tick();
        tick();
        ena = 1'b0;
        tick();
        tick();
        tick();
        nvec++;
        if (uio_out[7:6] !== 2'b01) begin nerr++; $display("FAIL stall_flags got %b want 01", uio_out[7:6]); end
        ena = 1'b1;
        wait_done(n);
        nvec++;
        if (n + 6 !== 12) begin nerr++; $display("FAIL stall_latency got %0d want 12", n + 6); end
        nvec++;
        if (uo_out !== 8'd28) begin nerr++; $display("FAIL stall_quot got %0d want 28", uo_out); end
        $display("ena stall -> uo_out=%0d after %0d cycles", uo_out, n + 6);
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_start(8'd255, 4'd15, 1'b0);
        nvec++;
        if (uio_out[7:6] !== 2'b01) begin nerr++; $display("FAIL b2b_done_clear got %b want 01", uio_out[7:6]); end
        wait_done(n);
        nvec++;
        if (n !== 9 || uo_out !== 8'd17) begin
            nerr++;
            $display("FAIL b2b_255_15 got n=%0d q=%0d want 9 17", n, uo_out);
        end
        pulse_start(8'd7, 4'd9, 1'b0);
        wait_done(n);
        nvec++;
        if (uo_out !== 8'd0) begin nerr++; $display("FAIL b2b_7_9 got %0d want 0", uo_out); end
        $display("back to back -> uo_out=%0d", uo_out);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_basic();
        test_rem();
        test_div0();
        test_ignore_restart();
        test_reset_mid_run();
        test_ena_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
